// File: rtl/i2c_request_arbiter.sv
// Round-robin arbiter letting NUM_REQ requesters share one write-only I2C master.
// Define I2C_ARB_TIMEOUT_EN to add a watchdog of TIMEOUT_CYCLES axi_clk cycles on the master handshake.
module i2c_request_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                  axi_clk,
  input  logic                  axi_resetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [7*NUM_REQ-1:0]  req_addr,
  input  logic [8*NUM_REQ-1:0]  req_reg,
  input  logic [32*NUM_REQ-1:0] req_data,
  input  logic [3*NUM_REQ-1:0]  req_byte_count,
  input  logic [NUM_REQ-1:0]    req_use_register,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [NUM_REQ-1:0]    error,
  output logic [31:0]           m_address_reg,
  output logic [31:0]           m_register_reg,
  output logic [31:0]           m_data_from_fifo,
  output logic [8:0]            m_control,
  input  logic                  m_clear_start_request,
  input  logic                  m_read_request,
  input  logic                  m_busy,
  input  logic                  m_ack_error
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("i2c_request_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START_REQ,
    WAIT_BUSY,
    RUN,
    COMPLETE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  int unsigned      cand;

  logic [6:0]       addr_q;
  logic [7:0]       reg_q;
  logic [31:0]      data_q;
  logic [2:0]       count_q;
  logic [3:0]       cnt_m1_q;
  logic             use_reg_q;
  logic             first_read_q;
  logic             ack_err_q;

  logic [2:0]       pick_count;
  logic             count_bad;
  logic             start;
  logic             timeout;

  // Search starts one position above the last grant and wraps once around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(last_idx) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_valid && req[IDX_W'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign pick_count = req_byte_count[3*pick_idx +: 3];
  assign count_bad  = (count_q == 3'd0) || (count_q > 3'd4);

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_active;

  assign tmo_active = (state == START_REQ) || (state == WAIT_BUSY) || (state == RUN);
  assign timeout    = tmo_active && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Restarts on every state change so each handshake phase gets the full budget.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      tmo_cnt <= '0;
    end else if (!tmo_active || (state_next != state)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (pick_valid) state_next = LOAD;
      LOAD:      state_next = count_bad ? IDLE : START_REQ;
      START_REQ: begin
        if (timeout)                    state_next = IDLE;
        else if (m_clear_start_request) state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (timeout)     state_next = IDLE;
        else if (m_busy) state_next = RUN;
      end
      RUN: begin
        if (timeout)                     state_next = IDLE;
        else if (!m_busy || m_ack_error) state_next = COMPLETE;
      end
      COMPLETE:  state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt   = '0;
    done  = '0;
    error = '0;
    start = 1'b0;
    if (state != IDLE) gnt[winner] = 1'b1;
    unique case (state)
      LOAD:      if (count_bad) error[winner] = 1'b1;
      START_REQ: start = !m_clear_start_request && !timeout;
      COMPLETE: begin
        if (ack_err_q || m_ack_error) error[winner] = 1'b1;
        else                          done[winner]  = 1'b1;
      end
      default: ;
    endcase
    if (timeout) error[winner] = 1'b1;
  end

  // Operands are captured when the winner is chosen so buses never follow live req inputs.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      last_idx     <= IDX_W'(NUM_REQ - 1);
      winner       <= '0;
      addr_q       <= '0;
      reg_q        <= '0;
      data_q       <= '0;
      count_q      <= '0;
      cnt_m1_q     <= '0;
      use_reg_q    <= 1'b0;
      first_read_q <= 1'b0;
      ack_err_q    <= 1'b0;
    end else begin
      if (state == IDLE && pick_valid) begin
        winner       <= pick_idx;
        last_idx     <= pick_idx;
        addr_q       <= req_addr[7*pick_idx +: 7];
        reg_q        <= req_reg[8*pick_idx +: 8];
        data_q       <= req_data[32*pick_idx +: 32];
        count_q      <= pick_count;
        cnt_m1_q     <= {1'b0, pick_count} - 4'd1;
        use_reg_q    <= req_use_register[pick_idx];
        first_read_q <= 1'b0;
        ack_err_q    <= 1'b0;
      end
      // Byte 0 is already presented, so only the second and later requests advance.
      if (state == RUN && m_read_request) begin
        if (first_read_q) data_q <= data_q >> 8;
        first_read_q <= 1'b1;
      end
      if ((state == WAIT_BUSY || state == RUN) && m_ack_error) begin
        ack_err_q <= 1'b1;
      end
    end
  end

  assign m_address_reg    = {25'd0, addr_q};
  assign m_register_reg   = {24'd0, reg_q};
  assign m_data_from_fifo = data_q;
  assign m_control        = {1'b0, start, 1'b0, use_reg_q, cnt_m1_q, 1'b0};

endmodule

// File: doc/i2c_request_arbiter.md
I2C_REQUEST_ARBITER -- requirements
Module: i2c_request_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one I2C master (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000, busy watchdog limit in axi_clk cycles (used only under REQ-032).
REQ-003 axi_clk  in  1  single clock; all logic on rising edge.
REQ-004 axi_resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 req  in  NUM_REQ  per-requester transaction request, level, held until done/error.
REQ-006 req_addr  in  7*NUM_REQ  7-bit target device address per requester.
REQ-007 req_reg  in  8*NUM_REQ  register address per requester.
REQ-008 req_data  in  32*NUM_REQ  write payload; byte 0 in [7:0], sent first.
REQ-009 req_byte_count  in  3*NUM_REQ  payload bytes, legal 1..4.
REQ-010 req_use_register  in  NUM_REQ  1 = send register address phase.
REQ-011 gnt  out  NUM_REQ  one-hot grant, high for the whole owned transaction.
REQ-012 done / error  out  NUM_REQ each  one-cycle completion pulses to the granted requester.
REQ-013 m_address_reg, m_register_reg, m_data_from_fifo  out  32 each  master operand buses.
REQ-014 m_control  out  9  master control word: [0] read_write, [4:1] byte_count, [5] use_register, [6] use_repeated_start, [7] start, [8] test_out.
REQ-015 m_clear_start_request, m_read_request, m_busy, m_ack_error  in  1 each  master handshake/status.

Function
REQ-016 SHALL be a state machine with states IDLE, LOAD, START_REQ, WAIT_BUSY, RUN, COMPLETE.
REQ-017 IDLE: when any req bit is set, pick the winner round-robin, starting one position above the last granted index; go to LOAD next cycle.
REQ-018 LOAD: assert gnt[winner]; latch addr, reg, data, count and use_register into internal registers; drive buses from these registers only.
REQ-019 LOAD with latched count 0 or >4: pulse error[winner] and return to IDLE without start; rotation pointer advances.
REQ-020 m_address_reg = {25'b0, addr}; m_register_reg = {24'b0, reg}; m_control[0]=0, [6]=0, [8]=0 always (write-only).
REQ-021 m_control[4:1] = latched count − 1, since the master sends byte_count+1 data bytes.
REQ-022 START_REQ: hold m_control[7]=1 until m_clear_start_request is sampled high, then clear [7] the same cycle and go to WAIT_BUSY.
REQ-023 WAIT_BUSY: go to RUN on the first cycle m_busy=1.
REQ-024 RUN: on each m_read_request pulse after the first, shift the data register right by 8 (zero fill), so m_data_from_fifo[7:0] is always the next byte.
REQ-025 RUN: when m_busy falls, or m_ack_error rises, go to COMPLETE.
REQ-026 COMPLETE: pulse done[winner] if m_ack_error=0, else error[winner]; deassert gnt; return to IDLE; one idle cycle is required before the next grant.
REQ-027 If req[winner] drops mid-transaction, the transaction SHALL still complete; a done/error pulse is still issued.
REQ-028 Simultaneous requests SHALL never both be granted; a requester re-asserting continuously SHALL wait at most NUM_REQ−1 transactions.

Reset
REQ-029 On axi_resetn low, all outputs SHALL go to 0 at once, state to IDLE, rotation pointer to NUM_REQ−1 (index 0 wins first).
REQ-030 Reset mid-transaction SHALL abandon it with no done/error pulse.
REQ-031 On release, the first req SHALL be evaluated on the next rising edge.

Configuration
REQ-032 Macro I2C_ARB_TIMEOUT_EN defined: a counter SHALL run in START_REQ, WAIT_BUSY and RUN, and clear on each state change. Reaching TIMEOUT_CYCLES SHALL pulse error[winner], drop start and return to IDLE.
REQ-033 Macro I2C_ARB_TIMEOUT_EN undefined: no counter exists; the block waits indefinitely on the master.

Verification
REQ-034 req=4'b0001, addr 0x50, count 2, data 0x0000BBAA, busy held 40 cycles -> control[4:1]=1, bytes AA then BB, done[0] pulse, gnt[0] cleared.
REQ-035 req=4'b1111 held -> grants in order 0,1,2,3,0; never more than one gnt bit high.
REQ-036 m_ack_error pulses during RUN for requester 2 -> error[2] one cycle, no done[2], next grant to 3.
REQ-037 req_byte_count=0 on requester 1 -> error[1] pulse, start never asserted.
REQ-038 axi_resetn low during RUN -> all outputs 0 asynchronously; after release req=4'b0011 -> gnt[0] first.
REQ-039 I2C_ARB_TIMEOUT_EN set, TIMEOUT_CYCLES=100, m_clear_start_request never asserted -> error pulse after 100 cycles in START_REQ, then IDLE.
